// File: rtl/c2h_packetizer.sv
// C2H stream packetizer: buffers upstream beats (FIFO -> hold H -> output O) and
// frames them with tlast every cfg_pkt_beats beats, or on idle timeout / flush.
module c2h_packetizer #(
  parameter int DATA_WIDTH = 512,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMER_W    = 16
) (
  input  logic                      c0_ddr4_clk,
  input  logic                      axi_resetn,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  input  logic [15:0]               cfg_pkt_beats,
  input  logic [TIMER_W-1:0]        cfg_timeout,
  input  logic                      flush,
  output logic [31:0]               pkt_count,
  output logic [31:0]               beat_count,
  output logic                      busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int KW = DATA_WIDTH / 8;
  localparam logic [TIMER_W-1:0] TMAX = {TIMER_W{1'b1}};

  // Handshake rule on both ports: a beat transfers on the rising edge where
  // tvalid & tready are both high; a raised tvalid holds its data until then.

  // Reset asserts asynchronously and releases after two clean edges.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge c0_ddr4_clk or negedge axi_resetn) begin
    if (!axi_resetn) rst_sync_q <= 2'b00;
    else             rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                  fifo_empty, fifo_full, fifo_wr, fifo_rd;
  logic [DATA_WIDTH-1:0] fifo_head;

  logic                  h_valid_q, h_valid_d;
  logic [DATA_WIDTH-1:0] h_data_q, h_data_d;
  logic                  o_valid_q, o_valid_d;
  logic [DATA_WIDTH-1:0] o_data_q, o_data_d;
  logic                  o_last_q, o_last_d;
  logic [15:0]           pos_q, pos_d;
  logic [15:0]           eff_q, eff_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic                  close_pend_q, close_pend_d;
  logic [31:0]           pkt_q, pkt_d, beat_q, beat_d;

  logic        m_hs, o_load, load_last, count_en, timer_hit;
  logic [15:0] eff_live, eff_cur;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_head  = mem_q[rd_ptr_q[AW-1:0]];

  assign s_axis_tready = rst_n & ~fifo_full;
  assign fifo_wr       = s_axis_tvalid & s_axis_tready;
  assign m_hs          = o_valid_q & m_axis_tready;

  // Packet length is latched at the start of each packet.
  assign eff_live  = (cfg_pkt_beats == 16'd0) ? 16'd1 : cfg_pkt_beats;
  assign eff_cur   = (pos_q == 16'd0) ? eff_live : eff_q;
  assign load_last = (pos_q == eff_cur - 16'd1) | close_pend_q;

  // H only advances once a successor exists or a close is pending, so any
  // beat leaving without tlast always has a follower.
  assign o_load  = (~o_valid_q | m_axis_tready) & h_valid_q & (~fifo_empty | close_pend_q);
  assign fifo_rd = ~fifo_empty & (o_load | ~h_valid_q);

  assign count_en  = h_valid_q & fifo_empty & ~fifo_wr;
  assign timer_hit = count_en && (cfg_timeout != '0) &&
                     (timer_q == cfg_timeout - TIMER_W'(1));

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    h_valid_d    = h_valid_q;
    h_data_d     = h_data_q;
    o_valid_d    = o_valid_q;
    o_data_d     = o_data_q;
    o_last_d     = o_last_q;
    pos_d        = pos_q;
    eff_d        = eff_q;
    timer_d      = '0;
    close_pend_d = close_pend_q;
    pkt_d        = pkt_q;
    beat_d       = beat_q;

    if (fifo_wr) wr_ptr_d = wr_ptr_q + (AW+1)'(1);

    if (fifo_rd) begin
      rd_ptr_d  = rd_ptr_q + (AW+1)'(1);
      h_valid_d = 1'b1;
      h_data_d  = fifo_head;
    end else if (o_load) begin
      h_valid_d = 1'b0;
    end

    if (o_load) begin
      o_valid_d = 1'b1;
      o_data_d  = h_data_q;
      o_last_d  = load_last;
      pos_d     = load_last ? 16'd0 : pos_q + 16'd1;
    end else if (m_hs) begin
      o_valid_d = 1'b0;
    end

    if (pos_q == 16'd0) eff_d = eff_live;

    if (count_en) timer_d = (timer_q == TMAX) ? timer_q : timer_q + TIMER_W'(1);

    // A close landing on a beat that already ends its packet is absorbed.
    if (o_load && load_last)                  close_pend_d = 1'b0;
    else if ((flush && h_valid_q) || timer_hit) close_pend_d = 1'b1;

    if (m_hs) begin
      beat_d = beat_q + 32'd1;
      if (o_last_q) pkt_d = pkt_q + 32'd1;
    end
  end

  always_ff @(posedge c0_ddr4_clk) begin
    if (fifo_wr) mem_q[wr_ptr_q[AW-1:0]] <= s_axis_tdata;
  end

  always_ff @(posedge c0_ddr4_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      h_valid_q    <= 1'b0;
      h_data_q     <= '0;
      o_valid_q    <= 1'b0;
      o_data_q     <= '0;
      o_last_q     <= 1'b0;
      pos_q        <= '0;
      eff_q        <= 16'd1;
      timer_q      <= '0;
      close_pend_q <= 1'b0;
      pkt_q        <= '0;
      beat_q       <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      h_valid_q    <= h_valid_d;
      h_data_q     <= h_data_d;
      o_valid_q    <= o_valid_d;
      o_data_q     <= o_data_d;
      o_last_q     <= o_last_d;
      pos_q        <= pos_d;
      eff_q        <= eff_d;
      timer_q      <= timer_d;
      close_pend_q <= close_pend_d;
      pkt_q        <= pkt_d;
      beat_q       <= beat_d;
    end
  end

  assign m_axis_tdata  = o_data_q;
  assign m_axis_tkeep  = {KW{o_valid_q}};
  assign m_axis_tlast  = o_valid_q & o_last_q;
  assign m_axis_tvalid = o_valid_q;
  assign pkt_count     = pkt_q;
  assign beat_count    = beat_q;
  assign busy          = ~fifo_empty | h_valid_q | o_valid_q;

endmodule
